// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encodings and decode helpers.
package univ_shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ModeHold = MODE_HOLD,
    ModeShl  = MODE_SHL,
    ModeShr  = MODE_SHR,
    ModeLoad = MODE_LOAD
  } mode_e;

  function automatic logic is_shift(mode_e m);
    return (m == ModeShl) || (m == ModeShr);
  endfunction

endpackage

// File: rtl/univ_shift_reg_frame_counter.sv
// Counts shifts within a WIDTH-shift frame and emits a registered one-cycle pulse on wrap.
module univ_shift_reg_frame_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          frame_done
);

  localparam logic [CW-1:0] CntMax = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_d, cnt_q;
  logic          done_d, done_q;

  // Clear wins over increment; the pulse is only ever raised by the wrapping shift.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (cnt_q == CntMax) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt        = cnt_q;
  assign frame_done = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift-left / shift-right / parallel load, optional rotate.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned     CW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             rot,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] A,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CW-1:0]    cnt,
  output logic             frame_done
);

  logic [WIDTH-1:0] a_d, a_q;
  logic             inc, clr;
  mode_e            mode_dec;

  assign mode_dec = mode_e'(mode);

  always_comb begin
    a_d = a_q;
    inc = 1'b0;
    clr = 1'b0;
    if (en) begin
      inc = is_shift(mode_dec);
      unique case (mode_dec)
        ModeHold: a_d = a_q;
        ModeShl:  a_d = {a_q[WIDTH-2:0], rot ? a_q[WIDTH-1] : sin_lsb};
        ModeShr:  a_d = {rot ? a_q[0] : sin_msb, a_q[WIDTH-1:1]};
        ModeLoad: begin
          a_d = pin;
          clr = 1'b1;
        end
        default:  a_d = a_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= RESET_VAL;
    end else begin
      a_q <= a_d;
    end
  end

  univ_shift_reg_frame_counter #(
    .WIDTH(WIDTH),
    .CW   (CW)
  ) u_frame_counter (
    .clk       (clk),
    .reset     (reset),
    .inc       (inc),
    .clr       (clr),
    .cnt       (cnt),
    .frame_done(frame_done)
  );

  assign A        = a_q;
  assign sout_msb = a_q[WIDTH-1];
  assign sout_lsb = a_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=4): SIPO, PISO, rotate, enable, reset and load cases.
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = MODE_HOLD;
  logic       rot = 1'b0;
  logic       sin_lsb = 1'b0;
  logic       sin_msb = 1'b0;
  logic [3:0] pin = 4'b0000;
  logic [3:0] A;
  logic       sout_msb, sout_lsb;
  logic [1:0] cnt;
  logic       frame_done;

  int total = 0;
  int bad   = 0;

  always #10 clk = ~clk;

  univ_shift_reg #(
    .WIDTH    (4),
    .RESET_VAL(4'b0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .rot       (rot),
    .sin_lsb   (sin_lsb),
    .sin_msb   (sin_msb),
    .pin       (pin),
    .A         (A),
    .sout_msb  (sout_msb),
    .sout_lsb  (sout_lsb),
    .cnt       (cnt),
    .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] ea, input logic [1:0] ec,
                           input logic ef);
    chk({tag, ".A"}, 32'(A), 32'(ea));
    chk({tag, ".cnt"}, 32'(cnt), 32'(ec));
    chk({tag, ".frame_done"}, 32'(frame_done), 32'(ef));
  endtask

  initial begin
    // 1: asynchronous reset takes effect without a clock edge
    #2 reset = 1'b0;
    #1 chk_state("reset", 4'b0000, 2'd0, 1'b0);
    #12 reset = 1'b1;

    // 2: SIPO shift-left
    en = 1'b1; mode = MODE_SHL; rot = 1'b0;
    sin_lsb = 1'b0; step(); chk_state("sipo1", 4'b0000, 2'd1, 1'b0);
    sin_lsb = 1'b1; step(); chk_state("sipo2", 4'b0001, 2'd2, 1'b0);
    sin_lsb = 1'b0; step(); chk_state("sipo3", 4'b0010, 2'd3, 1'b0);
    sin_lsb = 1'b0; step(); chk_state("sipo4", 4'b0100, 2'd0, 1'b1);
    sin_lsb = 1'b1; step(); chk_state("sipo5", 4'b1001, 2'd1, 1'b0);

    // 3: PISO load then shift-right
    mode = MODE_LOAD; pin = 4'b1011; step(); chk_state("piso_ld", 4'b1011, 2'd0, 1'b0);
    mode = MODE_SHR; sin_msb = 1'b0;
    chk("piso_sout0", 32'(sout_lsb), 32'd1); step(); chk_state("piso1", 4'b0101, 2'd1, 1'b0);
    chk("piso_sout1", 32'(sout_lsb), 32'd1); step(); chk_state("piso2", 4'b0010, 2'd2, 1'b0);
    chk("piso_sout2", 32'(sout_lsb), 32'd0); step(); chk_state("piso3", 4'b0001, 2'd3, 1'b0);
    chk("piso_sout3", 32'(sout_lsb), 32'd1); step(); chk_state("piso4", 4'b0000, 2'd0, 1'b1);
    mode = MODE_HOLD; step(); chk_state("piso_hold", 4'b0000, 2'd0, 1'b0);

    // 4: rotate; serial inputs set opposite to what rotation brings in
    mode = MODE_LOAD; pin = 4'b1000; step(); chk_state("rot_ld", 4'b1000, 2'd0, 1'b0);
    rot = 1'b1; sin_lsb = 1'b0; sin_msb = 1'b1;
    mode = MODE_SHL; step(); chk_state("rot_shl1", 4'b0001, 2'd1, 1'b0);
    step(); chk_state("rot_shl2", 4'b0010, 2'd2, 1'b0);
    chk("rot_sout_msb", 32'(sout_msb), 32'd0);
    mode = MODE_SHR; step(); chk_state("rot_shr", 4'b0001, 2'd3, 1'b0);
    en = 1'b0; mode = MODE_SHL;
    for (int i = 0; i < 3; i++) begin
      step(); chk_state("en_off", 4'b0001, 2'd3, 1'b0);
    end

    // 5: reset mid-frame discards the partial frame
    en = 1'b1; rot = 1'b0; mode = MODE_LOAD; pin = 4'b0000;
    step(); chk_state("rst_ld", 4'b0000, 2'd0, 1'b0);
    mode = MODE_SHL; sin_lsb = 1'b1;
    step(); step(); chk_state("rst_pre", 4'b0011, 2'd2, 1'b0);
    reset = 1'b0;
    #2 chk_state("rst_mid", 4'b0000, 2'd0, 1'b0);
    #3 reset = 1'b1;
    step(); chk_state("rst_sh1", 4'b0001, 2'd1, 1'b0);
    step(); chk_state("rst_sh2", 4'b0011, 2'd2, 1'b0);
    step(); chk_state("rst_sh3", 4'b0111, 2'd3, 1'b0);
    step(); chk_state("rst_sh4", 4'b1111, 2'd0, 1'b1);

    // 6: load mid-frame restarts the count
    mode = MODE_SHR; sin_msb = 1'b0;
    step(); chk_state("ld_sh1", 4'b0111, 2'd1, 1'b0);
    step(); chk_state("ld_sh2", 4'b0011, 2'd2, 1'b0);
    step(); chk_state("ld_sh3", 4'b0001, 2'd3, 1'b0);
    mode = MODE_LOAD; pin = 4'b0110; step(); chk_state("ld_mid", 4'b0110, 2'd0, 1'b0);
    mode = MODE_SHL; rot = 1'b1;
    step(); chk_state("ld_r1", 4'b1100, 2'd1, 1'b0);
    chk("ld_sout_msb", 32'(sout_msb), 32'd1);
    step(); chk_state("ld_r2", 4'b1001, 2'd2, 1'b0);
    step(); chk_state("ld_r3", 4'b0011, 2'd3, 1'b0);
    step(); chk_state("ld_r4", 4'b0110, 2'd0, 1'b1);
    mode = MODE_HOLD; step(); chk_state("ld_hold", 4'b0110, 2'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
